instruction_uc: RTL and testbench

//  Multicycle control unit driving the Instruction_FD datapath control inputs.

---
 rtl/instruction_uc_pkg.sv | 66 ++++++
 rtl/instruction_uc_if.sv | 29 ++
 rtl/instruction_uc_decode.sv | 64 ++++++
 rtl/instruction_uc.sv | 137 +++++++++++++
 tb/tb_instruction_uc.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_uc_pkg.sv
// instruction_uc_pkg
//  Shared definitions for the instruction_uc control unit: RV64 opcode
//  constants, FSM state encoding, instruction class, OP_MEM_I and
//  select_flags codes, and the decoder result record.
package instruction_uc_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ld/sd are the only memory widths handled (doubleword)
  localparam logic [2:0] F3_DOUBLE  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_BRANCH,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_ALU_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } class_t;

  // OP_MEM_I: ALU-B / address source select
  localparam logic [1:0] OPM_REG = 2'd0;
  localparam logic [1:0] OPM_MEM = 2'd1;
  localparam logic [1:0] OPM_IMM = 2'd2;

  // select_flags: branch condition presented to the datapath
  localparam logic [2:0] FLG_Z    = 3'd1;
  localparam logic [2:0] FLG_NZ   = 3'd2;
  localparam logic [2:0] FLG_N    = 3'd3;
  localparam logic [2:0] FLG_NN   = 3'd4;
  localparam logic [2:0] FLG_NONE = 3'd7;

  typedef struct packed {
    class_t     cls;
    logic       add_sub;
    logic [2:0] flag_code;
    logic       illegal;
  } decode_t;

  // Branch funct3 -> condition code; FLG_NONE marks an unsupported funct3.
  function automatic logic [2:0] branch_code(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return FLG_Z;   // beq
      3'b001:  return FLG_NZ;  // bne
      3'b100:  return FLG_N;   // blt
      3'b101:  return FLG_NN;  // bge
      default: return FLG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/instruction_uc_if.sv
// instruction_uc_if
//  Bundles the control unit's run/instruction inputs and its datapath
//  control outputs.
//   slave  : the control unit (takes run/instr, drives the strobes)
//   master : the side driving run/instr and observing the strobes
interface instruction_uc_if #(
  parameter int INSTR_W = 32
);
  logic               run;
  logic [INSTR_W-1:0] instr;
  logic               IR_load;
  logic               WE_mem;
  logic               WE_reg;
  logic [1:0]         OP_MEM_I;
  logic               ADD_SUB;
  logic               PC_load;
  logic [2:0]         select_flags;
  logic               halt;

  modport slave (
    input  run, instr,
    output IR_load, WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, select_flags, halt
  );

  modport master (
    output run, instr,
    input  IR_load, WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, select_flags, halt
  );
endinterface

// File: rtl/instruction_uc_decode.sv
// instruction_uc_decode
//  Purely combinational classifier for a latched instruction.
//  Ports:
//   opcode, funct3, funct7 : instruction fields (RV64 base layout)
//   dec                    : {class, add_sub, flag_code, illegal}
module instruction_uc_decode
  import instruction_uc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output decode_t    dec
);

  logic [2:0] br_code;

  assign br_code = branch_code(funct3);

  always_comb begin
    // Anything not explicitly recognised below stays illegal.
    dec.cls       = CLS_NOP;
    dec.add_sub   = 1'b0;
    dec.flag_code = FLG_NONE;
    dec.illegal   = 1'b1;

    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) begin
          dec.cls     = CLS_ALU;
          dec.add_sub = funct7[5];  // sub
          dec.illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b000) begin
          dec.cls     = CLS_ALU_IMM;
          dec.illegal = 1'b0;
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_DOUBLE) begin
          dec.cls     = CLS_LOAD;
          dec.illegal = 1'b0;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_DOUBLE) begin
          dec.cls     = CLS_STORE;
          dec.illegal = 1'b0;
        end
      end
      OPC_BRANCH: begin
        if (br_code != FLG_NONE) begin
          dec.cls       = CLS_BRANCH;
          dec.add_sub   = 1'b1;  // compare by subtraction
          dec.flag_code = br_code;
          dec.illegal   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_uc.sv
// instruction_uc
//  Multicycle Moore control unit for the Instruction_FD datapath.
//  Fetches and latches an instruction, classifies it in DECODE and walks
//  the matching execution path; illegal words park the unit in HALT until
//  reset.
//  Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : instruction_uc_if.slave (run, instr in; control strobes out)
module instruction_uc
  import instruction_uc_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  instruction_uc_if.slave  bus
);

  state_t     state_reg, state_next;
  // Only the fields the classifier needs: {funct7, funct3, opcode}
  logic [16:0] ir_reg;
  class_t     class_reg;
  logic       add_sub_reg;
  logic [2:0] flag_reg;
  decode_t    dec;

  instruction_uc_decode u_decode (
    .opcode (ir_reg[6:0]),
    .funct3 (ir_reg[9:7]),
    .funct7 (ir_reg[16:10]),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      ir_reg      <= '0;
      class_reg   <= CLS_NOP;
      add_sub_reg <= 1'b0;
      flag_reg    <= FLG_NONE;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_FETCH) begin
        ir_reg <= {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};
      end
      // Class is frozen on leaving DECODE so later states never look at
      // the raw word.
      if (state_reg == ST_DECODE) begin
        class_reg   <= dec.cls;
        add_sub_reg <= dec.add_sub;
        flag_reg    <= dec.flag_code;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.run || AUTO_RUN) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        if (dec.illegal) begin
          state_next = ST_HALT;
        end else begin
          case (dec.cls)
            CLS_ALU, CLS_ALU_IMM:  state_next = ST_EXEC;
            CLS_LOAD, CLS_STORE:   state_next = ST_MEM;
            CLS_BRANCH:            state_next = ST_BRANCH;
            default:               state_next = ST_HALT;
          endcase
        end
      end
      ST_EXEC:   state_next = ST_FETCH;
      ST_MEM:    state_next = (class_reg == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  logic       ir_load_o, we_mem_o, we_reg_o, add_sub_o, pc_load_o, halt_o;
  logic [1:0] op_mem_i_o;
  logic [2:0] select_flags_o;

  // Moore outputs: functions of state and latched class only.
  always_comb begin
    ir_load_o      = 1'b0;
    we_mem_o       = 1'b0;
    we_reg_o       = 1'b0;
    op_mem_i_o     = OPM_REG;
    add_sub_o      = 1'b0;
    pc_load_o      = 1'b0;
    select_flags_o = FLG_NONE;
    halt_o         = 1'b0;
    case (state_reg)
      ST_FETCH: ir_load_o = 1'b1;
      ST_EXEC: begin
        we_reg_o   = 1'b1;
        pc_load_o  = 1'b1;
        op_mem_i_o = (class_reg == CLS_ALU_IMM) ? OPM_IMM : OPM_REG;
        add_sub_o  = (class_reg == CLS_ALU) && add_sub_reg;
      end
      ST_MEM: begin
        op_mem_i_o = OPM_MEM;
        if (class_reg == CLS_STORE) begin
          we_mem_o  = 1'b1;
          pc_load_o = 1'b1;
        end
      end
      ST_WB: begin
        op_mem_i_o = OPM_MEM;
        we_reg_o   = 1'b1;
        pc_load_o  = 1'b1;
      end
      ST_BRANCH: begin
        add_sub_o      = 1'b1;
        select_flags_o = flag_reg;
        pc_load_o      = 1'b1;
      end
      ST_HALT: halt_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.IR_load      = ir_load_o;
  assign bus.WE_mem       = we_mem_o;
  assign bus.WE_reg       = we_reg_o;
  assign bus.OP_MEM_I     = op_mem_i_o;
  assign bus.ADD_SUB      = add_sub_o;
  assign bus.PC_load      = pc_load_o;
  assign bus.select_flags = select_flags_o;
  assign bus.halt         = halt_o;

endmodule

// File: tb/tb_instruction_uc.sv
// tb_instruction_uc
//  Self-checking bench: directed instructions followed by randomized ones,
//  each compared cycle by cycle against a per-instruction output schedule
//  derived from the instruction's class.
module tb_instruction_uc;

  typedef struct packed {
    logic       ir_load;
    logic       we_mem;
    logic       we_reg;
    logic [1:0] op_mem_i;
    logic       add_sub;
    logic       pc_load;
    logic [2:0] sel;
    logic       halt;
  } outv_t;

  logic clk = 1'b0;
  logic reset;

  instruction_uc_if #(.INSTR_W(32)) bus ();

  instruction_uc #(
    .INSTR_W  (32),
    .AUTO_RUN (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  outv_t exp_q[$];

  function automatic outv_t sample();
    outv_t v;
    v.ir_load  = bus.IR_load;
    v.we_mem   = bus.WE_mem;
    v.we_reg   = bus.WE_reg;
    v.op_mem_i = bus.OP_MEM_I;
    v.add_sub  = bus.ADD_SUB;
    v.pc_load  = bus.PC_load;
    v.sel      = bus.select_flags;
    v.halt     = bus.halt;
    return v;
  endfunction

  task automatic check_vec(input string tag, input outv_t got, input outv_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got{ir,wm,wr,op,as,pc,sel,h}=%b,%b,%b,%0d,%b,%b,%0d,%b expected=%b,%b,%b,%0d,%b,%b,%0d,%b",
               tag, got.ir_load, got.we_mem, got.we_reg, got.op_mem_i, got.add_sub,
               got.pc_load, got.sel, got.halt, exp.ir_load, exp.we_mem, exp.we_reg,
               exp.op_mem_i, exp.add_sub, exp.pc_load, exp.sel, exp.halt);
    end
  endtask

  // Quiet output vector: nothing asserted, no branch condition.
  function automatic outv_t quiet();
    outv_t v;
    v     = '0;
    v.sel = 3'd7;
    return v;
  endfunction

  // Reference model: queues the expected per-cycle outputs of one
  // instruction, starting at its FETCH cycle. Returns 0 for an illegal word
  // (schedule then ends in 20 HALT cycles).
  function automatic bit model(input logic [31:0] w);
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    outv_t f, d, a, b;
    f = quiet(); f.ir_load = 1'b1;
    d = quiet();
    exp_q.push_back(f);
    exp_q.push_back(d);
    a = quiet();
    b = quiet();
    if (opc == 7'h33 && f3 == 0 && (f7 == 7'h00 || f7 == 7'h20)) begin
      a.we_reg = 1; a.pc_load = 1; a.add_sub = (f7 == 7'h20);
      exp_q.push_back(a);
      return 1'b1;
    end
    if (opc == 7'h13 && f3 == 0) begin
      a.we_reg = 1; a.pc_load = 1; a.op_mem_i = 2;
      exp_q.push_back(a);
      return 1'b1;
    end
    if (opc == 7'h03 && f3 == 3) begin
      a.op_mem_i = 1;
      b.op_mem_i = 1; b.we_reg = 1; b.pc_load = 1;
      exp_q.push_back(a);
      exp_q.push_back(b);
      return 1'b1;
    end
    if (opc == 7'h23 && f3 == 3) begin
      a.op_mem_i = 1; a.we_mem = 1; a.pc_load = 1;
      exp_q.push_back(a);
      return 1'b1;
    end
    if (opc == 7'h63 && (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5)) begin
      a.add_sub = 1; a.pc_load = 1;
      a.sel = (f3 == 0) ? 3'd1 : (f3 == 1) ? 3'd2 : (f3 == 4) ? 3'd3 : 3'd4;
      exp_q.push_back(a);
      return 1'b1;
    end
    a.halt = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(a);
    return 1'b0;
  endfunction

  // Reset, check IDLE, then pulse run so the next posedge enters FETCH.
  task automatic restart(input string tag);
    reset = 1'b1;
    @(negedge clk);
    check_vec({tag, ".reset"}, sample(), quiet());
    reset = 1'b0;
    @(negedge clk);
    check_vec({tag, ".idle"}, sample(), quiet());
    bus.run = 1'b1;
  endtask

  // Runs one instruction from its FETCH cycle; stop_after>0 truncates the
  // schedule (for mid-instruction reset). Returns legality via 'legal'.
  task automatic exec_instr(input logic [31:0] w, input string tag,
                            input int stop_after, output bit legal);
    int n;
    bus.instr = w;
    exp_q.delete();
    legal = model(w);
    n = exp_q.size();
    if (stop_after > 0 && stop_after < n) n = stop_after;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_vec($sformatf("%s.c%0d", tag, i), sample(), exp_q[i]);
      bus.run = 1'b0;
    end
    $display("instr %08h %-6s cycles=%0d %s", w, tag, n, legal ? "legal" : "illegal");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int cat = $urandom_range(0, 11);
    case (cat)
      0, 1: begin
        w[6:0] = 7'h03;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'b011;
      end
      2, 3: begin
        w[6:0] = 7'h23;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'b011;
      end
      4, 5, 6: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 4) != 0) begin
          w[14:12] = 3'b000;
          w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end
      end
      7: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000;
      end
      8, 9: w[6:0] = 7'h63;
      default: ;  // fully random word, almost always illegal
    endcase
    return w;
  endfunction

  initial begin
    bit legal;
    reset     = 1'b1;
    bus.run   = 1'b0;
    bus.instr = '0;
    @(negedge clk);

    restart("start");
    exec_instr(32'h00103083, "ld",   0, legal);
    exec_instr(32'h002081B3, "add",  0, legal);
    exec_instr(32'h40118233, "sub",  0, legal);
    exec_instr(32'h003031A3, "sd",   0, legal);
    exec_instr(32'h00318263, "beq",  0, legal);
    exec_instr(32'h00A00093, "addi", 0, legal);
    // Interrupt ld in its MEM cycle (c2): reset must return to quiet IDLE.
    exec_instr(32'h00103083, "ld_rst", 3, legal);
    restart("midmem");
    exec_instr(32'hFFFFFFFF, "ill",  0, legal);
    restart("unhalt");

    for (int k = 0; k < 80; k++) begin
      exec_instr(rand_instr(), $sformatf("r%0d", k), 0, legal);
      if (!legal) restart($sformatf("r%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
